// File: rtl/enc_pkg.sv
// Shared decode-mode encodings, error counter width and the quadrature Gray
// forward-successor helper for the encoder front end.
package enc_pkg;

  typedef enum logic [1:0] {
    ENC_X1     = 2'b00,
    ENC_X2     = 2'b01,
    ENC_X4     = 2'b10,
    ENC_X4_ALT = 2'b11
  } enc_mode_e;

  localparam int unsigned ERR_CNT_W = 8;

  // Forward order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] gray_fwd_next(input logic [1:0] s);
    logic [1:0] n;
    case (s)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/enc_glitch_filter.sv
// Two-flop synchronizer followed by a stability filter: the filtered output
// follows the synchronized input only after FILT_LEN consecutive differing cycles.
module enc_glitch_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk48mhz,
  input  logic rstn,
  input  logic din,
  output logic sync_o,
  output logic filt_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic [7:0] cnt_q, cnt_d;
  logic       filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == 8'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Synchronizer runs through reset so the filter can preload a settled value.
  always_ff @(posedge clk48mhz) begin
    sync1_q <= din;
    sync2_q <= sync1_q;
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= sync2_q;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign sync_o = sync2_q;
  assign filt_o = filt_q;

endmodule

// File: rtl/enc_quad_decoder.sv
// Quadrature encoder front end: x1/x2/x4 decode, step pulses, position and
// phase-error monitor. Optional Z index path enabled by defining ENC_INDEX_EN.
module enc_quad_decoder
  import enc_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned POS_W    = 32
) (
  input  logic                 clk48mhz,
  input  logic                 rstn,
  input  logic                 enc_a,
  input  logic                 enc_b,
  input  logic [1:0]           decode_mode,
  input  logic                 invert_dir,
  input  logic                 clear_pos,
  input  logic                 error_clear,
  output logic                 count_enable_x,
  output logic                 count_rev,
  output logic                 count_dir,
  output logic [POS_W-1:0]     position,
  output logic                 phase_error,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef ENC_INDEX_EN
  ,
  input  logic                 enc_z,
  input  logic                 index_arm,
  output logic                 index_seen
`endif
);

  logic a_sync, a_filt, b_sync, b_filt;

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clk48mhz(clk48mhz), .rstn(rstn), .din(enc_a), .sync_o(a_sync), .filt_o(a_filt)
  );
  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clk48mhz(clk48mhz), .rstn(rstn), .din(enc_b), .sync_o(b_sync), .filt_o(b_filt)
  );

  logic [1:0]           prev_q;
  logic [1:0]           cur, diff;
  logic                 step_valid, illegal, fwd_raw, qual, fwd, rev, pos_clr;
  logic                 count_enable_x_q, count_enable_x_d;
  logic                 count_rev_q, count_rev_d;
  logic                 count_dir_q, count_dir_d;
  logic [POS_W-1:0]     position_q, position_d;
  logic                 phase_error_q, phase_error_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 index_evt;

`ifdef ENC_INDEX_EN
  logic z_sync, z_filt;
  logic z_prev_q;
  logic index_fired_q, index_fired_d;
  logic index_seen_q;

  enc_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
    .clk48mhz(clk48mhz), .rstn(rstn), .din(enc_z), .sync_o(z_sync), .filt_o(z_filt)
  );

  always_comb begin
    index_evt     = index_arm && !index_fired_q && z_filt && !z_prev_q;
    index_fired_d = index_arm && (index_fired_q || index_evt);
  end

  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      z_prev_q      <= z_sync;
      index_fired_q <= 1'b0;
      index_seen_q  <= 1'b0;
    end else begin
      z_prev_q      <= z_filt;
      index_fired_q <= index_fired_d;
      index_seen_q  <= index_evt;
    end
  end

  assign index_seen = index_seen_q;
`else
  assign index_evt = 1'b0;
`endif

  always_comb begin
    cur        = {a_filt, b_filt};
    diff       = cur ^ prev_q;
    step_valid = (diff == 2'b01) || (diff == 2'b10);
    illegal    = (diff == 2'b11);
    fwd_raw    = step_valid && (cur == gray_fwd_next(prev_q));

    case (enc_mode_e'(decode_mode))
      ENC_X1:  qual = ((prev_q == 2'b00) && (cur == 2'b10)) ||
                      ((prev_q == 2'b10) && (cur == 2'b00));
      ENC_X2:  qual = step_valid && diff[1];
      default: qual = step_valid;
    endcase

    // Direction swap applies after qualification so x1 keeps its 00<->10 edge.
    fwd     = qual && (fwd_raw ^ invert_dir);
    rev     = qual && !(fwd_raw ^ invert_dir);
    pos_clr = clear_pos || index_evt;

    count_enable_x_d = fwd;
    count_rev_d      = rev;
    count_dir_d      = count_dir_q;
    if (fwd) count_dir_d = 1'b1;
    if (rev) count_dir_d = 1'b0;

    position_d = position_q;
    if (pos_clr)  position_d = '0;
    else if (fwd) position_d = position_q + POS_W'(1);
    else if (rev) position_d = position_q - POS_W'(1);

    phase_error_d = phase_error_q;
    err_count_d   = err_count_q;
    if (illegal) begin
      phase_error_d = 1'b1;
      if (error_clear)            err_count_d = ERR_CNT_W'(1);
      else if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
    end else if (error_clear) begin
      phase_error_d = 1'b0;
      err_count_d   = '0;
    end
  end

  always_ff @(posedge clk48mhz) begin
    if (!rstn) begin
      prev_q           <= {a_sync, b_sync};
      count_enable_x_q <= 1'b0;
      count_rev_q      <= 1'b0;
      count_dir_q      <= 1'b0;
      position_q       <= '0;
      phase_error_q    <= 1'b0;
      err_count_q      <= '0;
    end else begin
      prev_q           <= cur;
      count_enable_x_q <= count_enable_x_d;
      count_rev_q      <= count_rev_d;
      count_dir_q      <= count_dir_d;
      position_q       <= position_d;
      phase_error_q    <= phase_error_d;
      err_count_q      <= err_count_d;
    end
  end

  assign count_enable_x = count_enable_x_q;
  assign count_rev      = count_rev_q;
  assign count_dir      = count_dir_q;
  assign position       = position_q;
  assign phase_error    = phase_error_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_enc_quad_decoder.sv
// Directed self-checking bench for enc_quad_decoder; index tests compile only
// when ENC_INDEX_EN is defined.
module tb_enc_quad_decoder;

  logic        clk48mhz = 1'b0;
  logic        rstn = 1'b0;
  logic        enc_a = 1'b0, enc_b = 1'b0;
  logic [1:0]  decode_mode = 2'b10;
  logic        invert_dir = 1'b0, clear_pos = 1'b0, error_clear = 1'b0;
  logic        count_enable_x, count_rev, count_dir, phase_error;
  logic [31:0] position;
  logic [7:0]  err_count;
`ifdef ENC_INDEX_EN
  logic        enc_z = 1'b0, index_arm = 1'b0, index_seen;
  int          idx_cnt = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int fwd_cnt  = 0, rev_cnt = 0, both_cnt = 0;

  enc_quad_decoder #(.FILT_LEN(4), .POS_W(32)) dut (
    .clk48mhz(clk48mhz), .rstn(rstn), .enc_a(enc_a), .enc_b(enc_b),
    .decode_mode(decode_mode), .invert_dir(invert_dir), .clear_pos(clear_pos),
    .error_clear(error_clear), .count_enable_x(count_enable_x),
    .count_rev(count_rev), .count_dir(count_dir), .position(position),
    .phase_error(phase_error), .err_count(err_count)
`ifdef ENC_INDEX_EN
    , .enc_z(enc_z), .index_arm(index_arm), .index_seen(index_seen)
`endif
  );

  always #10 clk48mhz = ~clk48mhz;

  always @(negedge clk48mhz) begin
    if (count_enable_x) fwd_cnt++;
    if (count_rev) rev_cnt++;
    if (count_enable_x && count_rev) both_cnt++;
`ifdef ENC_INDEX_EN
    if (index_seen) idx_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic a, input logic b);
    enc_a = a;
    enc_b = b;
    repeat (8) @(negedge clk48mhz);
  endtask

  task automatic fwd_cycle();
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
  endtask

  task automatic rev_cycle();
    step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic clr();
    clear_pos = 1'b1;
    @(negedge clk48mhz);
    clear_pos = 1'b0;
    @(negedge clk48mhz);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, r0, lat;
    logic [31:0] p0;

    repeat (5) @(negedge clk48mhz);
    check("rst_pos", 64'(position), 64'd0);
    check("rst_fwd", 64'(count_enable_x), 64'd0);
    check("rst_rev", 64'(count_rev), 64'd0);
    check("rst_dir", 64'(count_dir), 64'd0);
    check("rst_perr", 64'(phase_error), 64'd0);
    check("rst_errcnt", 64'(err_count), 64'd0);
    rstn = 1'b1;
    repeat (10) @(negedge clk48mhz);
    check("release_no_pulse", 64'(fwd_cnt + rev_cnt), 64'd0);

    // x4 forward with first-pulse latency measurement
    f0 = fwd_cnt; r0 = rev_cnt; lat = 0;
    enc_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk48mhz);
      if (count_enable_x && lat == 0) lat = i;
    end
    check("x4_latency", 64'(lat), 64'd7);
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    for (int c = 0; c < 9; c++) fwd_cycle();
    check("x4_fwd_pulses", 64'(fwd_cnt - f0), 64'd40);
    check("x4_fwd_rev0", 64'(rev_cnt - r0), 64'd0);
    check("x4_fwd_pos", 64'(position), 64'd40);
    check("x4_fwd_dir", 64'(count_dir), 64'd1);

    // x4 reverse through zero
    clr();
    check("clear_pos", 64'(position), 64'd0);
    f0 = fwd_cnt; r0 = rev_cnt;
    for (int c = 0; c < 4; c++) rev_cycle();
    check("x4_rev_pulses", 64'(rev_cnt - r0), 64'd16);
    check("x4_rev_fwd0", 64'(fwd_cnt - f0), 64'd0);
    check("x4_rev_pos", 64'(position), 64'hFFFF_FFF0);
    check("x4_rev_dir", 64'(count_dir), 64'd0);

    invert_dir = 1'b1;
    clr();
    f0 = fwd_cnt;
    for (int c = 0; c < 4; c++) rev_cycle();
    check("inv_pos", 64'(position), 64'd16);
    check("inv_pulses", 64'(fwd_cnt - f0), 64'd16);
    check("inv_dir", 64'(count_dir), 64'd1);
    invert_dir = 1'b0;

    decode_mode = 2'b00;
    clr();
    f0 = fwd_cnt;
    for (int c = 0; c < 10; c++) fwd_cycle();
    check("x1_pulses", 64'(fwd_cnt - f0), 64'd10);
    check("x1_pos", 64'(position), 64'd10);

    decode_mode = 2'b01;
    clr();
    f0 = fwd_cnt;
    for (int c = 0; c < 10; c++) fwd_cycle();
    check("x2_pulses", 64'(fwd_cnt - f0), 64'd20);
    check("x2_pos", 64'(position), 64'd20);

    // glitch rejection and threshold
    decode_mode = 2'b10;
    p0 = position; f0 = fwd_cnt; r0 = rev_cnt;
    enc_a = 1'b1; repeat (3) @(negedge clk48mhz);
    enc_a = 1'b0; repeat (12) @(negedge clk48mhz);
    check("glitch3_pulses", 64'(fwd_cnt - f0 + rev_cnt - r0), 64'd0);
    check("glitch3_pos", 64'(position), 64'(p0));
    enc_a = 1'b1; repeat (4) @(negedge clk48mhz);
    enc_a = 1'b0; repeat (14) @(negedge clk48mhz);
    check("glitch4_fwd", 64'(fwd_cnt - f0), 64'd1);
    check("glitch4_rev", 64'(rev_cnt - r0), 64'd1);
    check("glitch4_pos", 64'(position), 64'(p0));

    // illegal transitions
    f0 = fwd_cnt; r0 = rev_cnt;
    step(1'b1, 1'b1);
    check("illegal_flag", 64'(phase_error), 64'd1);
    check("illegal_cnt", 64'(err_count), 64'd1);
    check("illegal_pos", 64'(position), 64'(p0));
    check("illegal_no_pulse", 64'(fwd_cnt - f0 + rev_cnt - r0), 64'd0);
    error_clear = 1'b1; @(negedge clk48mhz); error_clear = 1'b0;
    @(negedge clk48mhz);
    check("errclr_flag", 64'(phase_error), 64'd0);
    check("errclr_cnt", 64'(err_count), 64'd0);
    for (int i = 0; i < 300; i++) begin
      enc_a = ~enc_a; enc_b = ~enc_b;
      repeat (6) @(negedge clk48mhz);
    end
    repeat (4) @(negedge clk48mhz);
    check("err_saturate", 64'(err_count), 64'd255);
    enc_a = 1'b0; enc_b = 1'b0;
    repeat (6) @(negedge clk48mhz);
    error_clear = 1'b1; @(negedge clk48mhz); error_clear = 1'b0;
    check("err_vs_clear_flag", 64'(phase_error), 64'd1);
    check("err_vs_clear_cnt", 64'(err_count), 64'd1);
    check("mutual_excl", 64'(both_cnt), 64'd0);

`ifdef ENC_INDEX_EN
    repeat (4) @(negedge clk48mhz);
    clr();
    for (int c = 0; c < 30; c++) fwd_cycle();
    step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b1);
    check("idx_pre_pos", 64'(position), 64'd123);
    index_arm = 1'b1;
    enc_z = 1'b1; repeat (10) @(negedge clk48mhz);
    check("idx_pos", 64'(position), 64'd0);
    check("idx_once", 64'(idx_cnt), 64'd1);
    step(1'b0, 1'b0);
    enc_z = 1'b0; repeat (8) @(negedge clk48mhz);
    enc_z = 1'b1; repeat (10) @(negedge clk48mhz);
    check("idx_ignored_pos", 64'(position), 64'd1);
    check("idx_ignored_cnt", 64'(idx_cnt), 64'd1);
    index_arm = 1'b0; @(negedge clk48mhz); index_arm = 1'b1;
    enc_z = 1'b0; repeat (8) @(negedge clk48mhz);
    enc_z = 1'b1; repeat (10) @(negedge clk48mhz);
    check("idx_rearm_cnt", 64'(idx_cnt), 64'd2);
    check("idx_rearm_pos", 64'(position), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
